irq_aggregator: RTL and testbench

// Parametrised interrupt controller that collects asynchronous status inputs (pcm9211_int0/1,
// dac_zero_l/r, spare lines) into one active-low interrupt for the rPi host. Replaces the flat

---
 rtl/irq_aggregator.sv | 126 ++++++++++++
 tb/tb_irq_aggregator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-source synchroniser, debounce, polarity, level/edge capture,
// sticky pending with write-1-to-clear, masked priority encode and a gapped active-low irq_n.
module irq_aggregator #(
    parameter int NUM_SRC      = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int IRQ_GAP      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [NUM_SRC-1:0] mask_reg,
    input  logic [NUM_SRC-1:0] mode_reg,
    input  logic [NUM_SRC-1:0] polarity_reg,
    input  logic               clr_stb,
    input  logic [NUM_SRC-1:0] clr_data,
    output logic [NUM_SRC-1:0] raw_status,
    output logic [NUM_SRC-1:0] pending,
    output logic [3:0]         first_src,
    output logic               first_valid,
    output logic               irq_n
);

    localparam int CNT_W    = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int INIT_LEN = SYNC_STAGES + DEBOUNCE_CYC + 1;
    localparam int INIT_W   = $clog2(INIT_LEN + 1);
    localparam int GAP_W    = $clog2(IRQ_GAP + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                                state;
    logic [INIT_W-1:0]                     init_cnt;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   sync_q;
    logic [NUM_SRC-1:0]                    sync_out;
    logic [NUM_SRC-1:0]                    filtered;
    logic [NUM_SRC-1:0]                    filtered_nxt;
    logic [NUM_SRC-1:0][CNT_W-1:0]         deb_cnt;
    logic [NUM_SRC-1:0][CNT_W-1:0]         deb_cnt_nxt;
    logic [NUM_SRC-1:0]                    active;
    logic [NUM_SRC-1:0]                    prev_active;
    logic [NUM_SRC-1:0]                    set_vec;
    logic [NUM_SRC-1:0]                    clr_vec;
    logic [NUM_SRC-1:0]                    pending_nxt;
    logic [NUM_SRC-1:0]                    pend_mask;
    logic                                  req;
    logic [3:0]                            first_nxt;
    logic [GAP_W-1:0]                      gap_cnt;

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign active     = ~(filtered ^ polarity_reg);
    assign raw_status = active;

    // A change reaches filtered only after DEBOUNCE_CYC+1 consecutive disagreeing samples.
    always_comb begin
        filtered_nxt = filtered;
        deb_cnt_nxt  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (state == ST_INIT) begin
                filtered_nxt[i] = sync_out[i];
            end else if (sync_out[i] != filtered[i]) begin
                if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYC))
                    filtered_nxt[i] = sync_out[i];
                else
                    deb_cnt_nxt[i] = deb_cnt[i] + 1'b1;
            end
        end
    end

    // Set beats clear, so a still-active level source re-pends in the clearing cycle.
    assign set_vec     = active & ~(mode_reg & prev_active);
    assign clr_vec     = clr_stb ? clr_data : '0;
    assign pending_nxt = (state == ST_INIT) ? '0 : ((pending & ~clr_vec) | set_vec);
    assign pend_mask   = pending & mask_reg;
    assign req         = |pend_mask;

    always_comb begin
        first_nxt = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_mask[i])
                first_nxt = 4'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            sync_q      <= '0;
            filtered    <= '0;
            deb_cnt     <= '0;
            prev_active <= '0;
            pending     <= '0;
            first_src   <= '0;
            first_valid <= 1'b0;
            gap_cnt     <= '0;
            irq_n       <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], src_in};
            filtered    <= filtered_nxt;
            deb_cnt     <= deb_cnt_nxt;
            prev_active <= active;
            pending     <= pending_nxt;
            first_src   <= first_nxt;
            first_valid <= req;

            if (state == ST_INIT) begin
                if (init_cnt == INIT_W'(INIT_LEN - 1))
                    state <= ST_RUN;
                else
                    init_cnt <= init_cnt + 1'b1;
            end

            // irq_n is held high for IRQ_GAP cycles after every clear so the host sees a new edge.
            if (clr_stb) begin
                gap_cnt <= GAP_W'(IRQ_GAP - 1);
                irq_n   <= 1'b1;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
                irq_n   <= 1'b1;
            end else begin
                irq_n   <= ~req;
            end
        end
    end

endmodule

// File: tb/tb_irq_aggregator.sv
// Self-checking bench for irq_aggregator: directed scenarios plus randomized traffic
// compared against a history-based behavioural model.
module tb_irq_aggregator;

    localparam int NS       = 8;
    localparam int SYNC     = 2;
    localparam int DEB      = 16;
    localparam int GAP      = 4;
    localparam int INIT_LEN = SYNC + DEB + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NS-1:0] src_in = '0, mask_reg = '0, mode_reg = '0, polarity_reg = '0;
    logic          clr_stb = 1'b0;
    logic [NS-1:0] clr_data = '0;
    logic [NS-1:0] raw_status, pending;
    logic [3:0]    first_src;
    logic          first_valid, irq_n;

    int errors = 0;
    int checks = 0;

    irq_aggregator #(.NUM_SRC(NS), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB), .IRQ_GAP(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .src_in(src_in), .mask_reg(mask_reg), .mode_reg(mode_reg),
        .polarity_reg(polarity_reg), .clr_stb(clr_stb), .clr_data(clr_data),
        .raw_status(raw_status), .pending(pending), .first_src(first_src),
        .first_valid(first_valid), .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model state
    logic [NS-1:0] m_sync [SYNC];
    logic [NS-1:0] m_hist [$];
    logic [NS-1:0] m_filt, m_prev_act, m_pend;
    logic [3:0]    m_first_src;
    logic          m_first_valid, m_irq_n;
    int            m_cyc, m_last_clr;

    task automatic model_reset();
        for (int j = 0; j < SYNC; j++) m_sync[j] = '0;
        m_hist.delete();
        m_filt = '0; m_prev_act = '0; m_pend = '0;
        m_first_src = '0; m_first_valid = 1'b0; m_irq_n = 1'b1;
        m_cyc = 0; m_last_clr = -1000;
    endtask

    task automatic model_step(input logic [NS-1:0] s, pl, md, mk, input logic cs, input logic [NS-1:0] cd);
        logic [NS-1:0] sync_old, act, new_filt, set_v, req_v, new_pend;
        logic          all_diff;
        int            edge_no;
        bit            in_init;
        in_init  = (m_cyc < INIT_LEN);
        edge_no  = m_cyc + 1;
        sync_old = m_sync[SYNC-1];
        act      = ~(m_filt ^ pl);
        new_filt = m_filt;
        if (in_init) begin
            new_filt = sync_old;
        end else begin
            m_hist.push_back(sync_old);
            if (m_hist.size() > DEB + 1) void'(m_hist.pop_front());
            for (int i = 0; i < NS; i++) begin
                if (m_hist.size() == DEB + 1) begin
                    all_diff = 1'b1;
                    foreach (m_hist[h]) if (m_hist[h][i] == m_filt[i]) all_diff = 1'b0;
                    if (all_diff) new_filt[i] = ~m_filt[i];
                end
            end
        end
        set_v    = (~md & act) | (md & act & ~m_prev_act);
        new_pend = in_init ? '0 : ((m_pend & ~(cs ? cd : '0)) | set_v);
        req_v    = m_pend & mk;
        m_first_valid = |req_v;
        m_first_src   = '0;
        for (int i = NS - 1; i >= 0; i--) if (req_v[i]) m_first_src = 4'(i);
        if (cs) m_last_clr = edge_no;
        m_irq_n = (edge_no - m_last_clr < GAP) ? 1'b1 : ~(|req_v);
        for (int j = SYNC - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
        m_sync[0]  = s;
        m_prev_act = act;
        m_filt     = new_filt;
        m_pend     = new_pend;
        m_cyc      = m_cyc + 1;
    endtask

    task automatic tick();
        logic [NS-1:0] s, pl, md, mk, cd;
        logic cs, rn;
        s = src_in; pl = polarity_reg; md = mode_reg; mk = mask_reg; cs = clr_stb; cd = clr_data;
        rn = reset_n;
        @(posedge clk);
        if (rn) model_step(s, pl, md, mk, cs, cd);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr_stb = 1'b0;
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_init();
        repeat (INIT_LEN + 2) tick();
    endtask

    task automatic test_reset();
        src_in = 8'hFF; polarity_reg = 8'h00; mode_reg = 8'h00; mask_reg = 8'hFF;
        reset_n = 1'b0;
        model_reset();
        repeat (2) tick();
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", pending); end
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
        checks++; if (first_valid !== 1'b0 || first_src !== 4'd0) begin errors++; $display("FAIL reset_first: got %b/%0d want 0/0", first_valid, first_src); end
        checks++; if (raw_status !== 8'hFF) begin errors++; $display("FAIL reset_raw: got %h want FF", raw_status); end
        reset_n = 1'b1;
        for (int c = 0; c < INIT_LEN + 20; c++) begin
            tick();
            checks++; if (pending !== 8'h00) begin errors++; $display("FAIL init_pending c%0d: got %h want 00", c, pending); end
            checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL init_irq_n c%0d: got %b want 1", c, irq_n); end
            checks++; if (raw_status !== ~(m_filt ^ polarity_reg)) begin errors++; $display("FAIL init_raw c%0d: got %h want %h", c, raw_status, ~(m_filt ^ polarity_reg)); end
        end
        checks++; if (raw_status !== 8'h00) begin errors++; $display("FAIL init_raw_final: got %h want 00", raw_status); end
    endtask

    task automatic test_debounce();
        int lat;
        src_in = 8'h00; polarity_reg = 8'hFF; mode_reg = 8'hFF; mask_reg = 8'hFF;
        do_reset();
        wait_init();
        src_in = 8'h01;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) src_in = 8'h00;
            tick();
            checks++; if (raw_status !== 8'h00 || pending !== 8'h00) begin errors++; $display("FAIL glitch c%0d: raw=%h pend=%h want 00/00", c, raw_status, pending); end
        end
        src_in = 8'h01;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (lat < 0 && raw_status[0] === 1'b1) lat = k;
            if (k == 18) begin
                checks++; if (raw_status[0] !== 1'b0) begin errors++; $display("FAIL deb_early: raw0=%b want 0", raw_status[0]); end
            end
            if (k == 20) begin
                checks++; if (pending !== 8'h01) begin errors++; $display("FAIL deb_pend: got %h want 01", pending); end
                checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL deb_irq_pre: got %b want 1", irq_n); end
            end
        end
        checks++; if (lat !== SYNC + DEB + 1) begin errors++; $display("FAIL deb_latency: got %0d want %0d", lat, SYNC + DEB + 1); end
        src_in = 8'h00;
        tick();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL deb_irq: got %b want 0", irq_n); end
        checks++; if (pending !== m_pend) begin errors++; $display("FAIL deb_model: got %h want %h", pending, m_pend); end
    endtask

    task automatic test_edge_level();
        src_in = 8'h00; polarity_reg = 8'hFF; mode_reg = 8'h04; mask_reg = 8'hFF;
        do_reset();
        wait_init();
        src_in = 8'h06;
        repeat (25) tick();
        checks++; if (pending !== 8'h06 || irq_n !== 1'b0) begin errors++; $display("FAIL el_setup: pend=%h irq=%b want 06/0", pending, irq_n); end
        clr_stb = 1'b1; clr_data = 8'h06;
        tick();
        clr_stb = 1'b0; clr_data = 8'h00;
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL el_clear: got %h want 02", pending); end
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL el_gap0: got %b want 1", irq_n); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (irq_n !== ((k < 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL el_gap k%0d: got %b want %b", k, irq_n, (k < 4)); end
        end
    endtask

    task automatic test_mask_priority();
        src_in = 8'h00; polarity_reg = 8'hFF; mode_reg = 8'hFF; mask_reg = 8'h00;
        do_reset();
        wait_init();
        src_in = 8'h28;
        repeat (25) tick();
        checks++; if (pending !== 8'h28) begin errors++; $display("FAIL mp_pend: got %h want 28", pending); end
        checks++; if (irq_n !== 1'b1 || first_valid !== 1'b0) begin errors++; $display("FAIL mp_masked: irq=%b fv=%b want 1/0", irq_n, first_valid); end
        mask_reg = 8'hFF;
        tick();
        checks++; if (first_src !== 4'd3 || first_valid !== 1'b1) begin errors++; $display("FAIL mp_first: got %0d/%b want 3/1", first_src, first_valid); end
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL mp_irq: got %b want 0", irq_n); end
        clr_stb = 1'b1; clr_data = 8'h08;
        tick();
        clr_stb = 1'b0; clr_data = 8'h00;
        checks++; if (pending !== 8'h20) begin errors++; $display("FAIL mp_clr: got %h want 20", pending); end
        tick();
        checks++; if (first_src !== 4'd5 || first_valid !== 1'b1) begin errors++; $display("FAIL mp_first2: got %0d/%b want 5/1", first_src, first_valid); end
    endtask

    task automatic test_simultaneous();
        int n;
        src_in = 8'h00; polarity_reg = 8'hFF; mode_reg = 8'hFF; mask_reg = 8'hFF;
        do_reset();
        wait_init();
        src_in = 8'h40;
        repeat (25) tick();
        checks++; if (pending !== 8'h40) begin errors++; $display("FAIL sim_setup: got %h want 40", pending); end
        src_in = 8'h50;
        n = 0;
        while (raw_status[4] !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (raw_status[4] !== 1'b1) begin errors++; $display("FAIL sim_timeout: raw4=%b want 1", raw_status[4]); end
        checks++; if (pending !== 8'h40) begin errors++; $display("FAIL sim_pre: got %h want 40", pending); end
        clr_stb = 1'b1; clr_data = 8'h50;
        tick();
        clr_stb = 1'b0; clr_data = 8'h00;
        checks++; if (pending !== 8'h10) begin errors++; $display("FAIL sim_setwins: got %h want 10", pending); end
    endtask

    task automatic test_reset_mid();
        src_in = 8'h00; polarity_reg = 8'hFF; mode_reg = 8'h00; mask_reg = 8'hFF;
        do_reset();
        wait_init();
        src_in = 8'hFF;
        repeat (25) tick();
        checks++; if (pending !== 8'hFF) begin errors++; $display("FAIL rm_pend: got %h want FF", pending); end
        clr_stb = 1'b1; clr_data = 8'h00;
        tick();
        clr_stb = 1'b0;
        tick();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL rm_gap: got %b want 1", irq_n); end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        checks++; if (pending !== 8'h00 || irq_n !== 1'b1) begin errors++; $display("FAIL rm_async: pend=%h irq=%b want 00/1", pending, irq_n); end
        checks++; if (first_valid !== 1'b0 || first_src !== 4'd0) begin errors++; $display("FAIL rm_first: got %b/%0d want 0/0", first_valid, first_src); end
        checks++; if (raw_status !== 8'h00) begin errors++; $display("FAIL rm_raw: got %h want 00", raw_status); end
        tick();
    endtask

    task automatic test_random();
        logic [NS-1:0] flip;
        src_in = 8'($urandom); polarity_reg = 8'($urandom); mode_reg = 8'($urandom); mask_reg = 8'($urandom);
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            flip = '0;
            for (int b = 0; b < NS; b++) if ($urandom_range(0, 39) == 0) flip[b] = 1'b1;
            src_in   = src_in ^ flip;
            clr_stb  = ($urandom_range(0, 9) == 0);
            clr_data = 8'($urandom);
            if ($urandom_range(0, 49) == 0) mask_reg = 8'($urandom);
            if ($urandom_range(0, 199) == 0) polarity_reg = 8'($urandom);
            if ($urandom_range(0, 199) == 0) mode_reg = 8'($urandom);
            tick();
            checks++; if (raw_status !== ~(m_filt ^ polarity_reg)) begin errors++; $display("FAIL rnd_raw c%0d: got %h want %h", c, raw_status, ~(m_filt ^ polarity_reg)); end
            checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pend c%0d: got %h want %h", c, pending, m_pend); end
            checks++; if (first_src !== m_first_src || first_valid !== m_first_valid) begin errors++; $display("FAIL rnd_first c%0d: got %0d/%b want %0d/%b", c, first_src, first_valid, m_first_src, m_first_valid); end
            checks++; if (irq_n !== m_irq_n) begin errors++; $display("FAIL rnd_irq c%0d: got %b want %b", c, irq_n, m_irq_n); end
        end
        clr_stb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_edge_level();
        test_mask_priority();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
